// File: rtl/win_acc_pkg.sv
// Shared types and width helpers for the window accumulator.
package win_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    localparam int unsigned DEF_IN_W   = 20;
    localparam int unsigned DEF_WINDOW = 4;

    function automatic int unsigned out_w_f(input int unsigned in_w, input int unsigned window);
        return in_w + int'($clog2(window));
    endfunction

    function automatic int unsigned cnt_w_f(input int unsigned window);
        return int'($clog2(window)) + 1;
    endfunction

endpackage

// File: rtl/window_accumulator.sv
// Sums WINDOW consecutive samples and emits one widened sum per window (or a
// partial sum on flush) over a valid/ready handshake.
module window_accumulator
    import win_acc_pkg::*;
#(
    parameter int unsigned IN_W   = DEF_IN_W,
    parameter int unsigned WINDOW = DEF_WINDOW
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [IN_W-1:0]                      in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic                                 flush,
    output logic [out_w_f(IN_W, WINDOW)-1:0]     out_data,
    output logic [cnt_w_f(WINDOW)-1:0]           out_cnt,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int unsigned OUT_W = out_w_f(IN_W, WINDOW);
    localparam int unsigned CNT_W = cnt_w_f(WINDOW);

    state_e             state, state_n;
    logic [OUT_W-1:0]   acc, acc_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [OUT_W-1:0]   out_data_n;
    logic [CNT_W-1:0]   out_cnt_n;
    logic               out_valid_n;
    logic               rdy_en;
    logic               accept_c;
    logic [OUT_W-1:0]   sum_c;

    // Ready depends on out_ready so a draining HOLD can take the next sample.
    assign in_ready = rdy_en && ((state == ACCUM) || out_ready);
    assign accept_c = in_valid && in_ready;
    assign sum_c    = acc + OUT_W'(in_data);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            rdy_en    <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            out_data  <= out_data_n;
            out_cnt   <= out_cnt_n;
            out_valid <= out_valid_n;
            rdy_en    <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        acc_n       = acc;
        cnt_n       = cnt;
        out_data_n  = out_data;
        out_cnt_n   = out_cnt;
        out_valid_n = out_valid;
        case (state)
            ACCUM: begin
                if (accept_c && (cnt == CNT_W'(WINDOW - 1))) begin
                    out_data_n  = sum_c;
                    out_cnt_n   = CNT_W'(WINDOW);
                    out_valid_n = 1'b1;
                    acc_n       = '0;
                    cnt_n       = '0;
                    state_n     = HOLD;
                end else if (flush && (accept_c || (cnt != '0))) begin
                    out_data_n  = accept_c ? sum_c : acc;
                    out_cnt_n   = accept_c ? cnt + CNT_W'(1) : cnt;
                    out_valid_n = 1'b1;
                    acc_n       = '0;
                    cnt_n       = '0;
                    state_n     = HOLD;
                end else if (accept_c) begin
                    acc_n = sum_c;
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            HOLD: begin
                // Accumulator is already cleared, so a sample taken on the
                // handshake cycle starts the next window.
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = ACCUM;
                    if (accept_c) begin
                        acc_n = OUT_W'(in_data);
                        cnt_n = CNT_W'(1);
                    end
                end
            end
            default: state_n = ACCUM;
        endcase
    end

endmodule

// File: doc/window_accumulator.md
Name: window_accumulator

Overview:
Downstream consumer of the parameterised datapath stage's wide output word. It sums a fixed window of consecutive samples and emits one widened sum per window over a valid/ready handshake. It supports an early flush that emits a partial window. It sits between the datapath stage and the result sink, and absorbs sink backpressure without losing samples.

Parameters:
IN_W, 20, width of each input sample (matches the upstream stage's output width).
WINDOW, 4, samples per sum; power of two, minimum 2.
OUT_W, IN_W+$clog2(WINDOW), localparam; sum width; no overflow is possible.
CNT_W, $clog2(WINDOW)+1, localparam; width of the sample-count field.

Ports:
clk  in  1  single clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
in_data  in  IN_W  unsigned sample from the upstream stage.
in_valid  in  1  in_data is valid.
in_ready  out  1  block accepts a sample this cycle.
flush  in  1  single-cycle pulse; emit the partial window now.
out_data  out  OUT_W  unsigned window sum.
out_cnt  out  CNT_W  number of samples in out_data (1..WINDOW).
out_valid  out  1  out_data and out_cnt are valid.
out_ready  in  1  sink accepts the result.

Behaviour:
- Reset values: out_data=0, out_cnt=0, out_valid=0, acc=0, cnt=0, state=ACCUM, rdy_en=0. in_ready is 0 while reset is asserted.
- rdy_en rises on the first clk edge after reset deasserts.
- in_ready = rdy_en && (state==ACCUM || out_ready). This is combinational from out_ready; there is no combinational path from in_valid.
- Accept = in_valid && in_ready. Unsigned add; acc is OUT_W wide, and in_data is zero-extended.
- States are ACCUM and HOLD.
- ACCUM:
  - Accept with cnt<WINDOW-1: acc+=in_data, cnt+=1.
  - Accept with cnt==WINDOW-1: out_data=acc+in_data, out_cnt=WINDOW, out_valid=1, acc=0, cnt=0, go to HOLD.
  - flush with cnt>0 (or a same-cycle accept): out_data=acc(+in_data if accepted), out_cnt=cnt(+1), out_valid=1, acc=0, cnt=0, go to HOLD.
  - flush with cnt==0 and no accept: ignored.
- HOLD:
  - out_data and out_cnt stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0, go to ACCUM. A sample accepted in that same cycle is added to the cleared accumulator (acc=in_data, cnt=1). WINDOW>=2 guarantees it cannot complete a window.
  - flush in HOLD: ignored, with no side effects.
- Latency: out_valid rises on the edge that accepts the final sample or the flush, i.e. registered and visible the next cycle.
- Full throughput: with out_ready held 1, in_ready never drops and back-to-back windows need no bubbles.
- Reset mid-window: the partial sum is discarded and no output is produced.
- out_valid, once asserted, is never deasserted without a handshake (except by reset).

Decomposition:
- Package win_acc_pkg holds:
  - state_e enum {ACCUM, HOLD};
  - the default IN_W/WINDOW constants;
  - a function computing OUT_W/CNT_W from IN_W/WINDOW.
- Single module. No sub-module is warranted: the accumulator, counter and output register are one tightly coupled FSM.

Test Plan:
- WINDOW=4, out_ready=1. Feed 123, 456, 7, 1000 back-to-back → one cycle after the 4th accept, out_valid=1, out_data=1586, out_cnt=4; in_ready stays 1 throughout.
- Overflow width. Four samples of 0xFFFFF → out_data=0x3FFFFC (22 bits), no truncation.
- Backpressure. Complete a window with out_ready=0 held for 5 cycles → out_data/out_cnt stable, out_valid=1, in_ready=0, no samples accepted. Then raise out_ready with in_valid=1 and in_data=9 → handshake completes, and the next output sums 9 plus 3 later samples.
- Flush. Feed 10 and 20, then pulse flush → out_data=30, out_cnt=2. Flush with a same-cycle sample 5 after 10, 20 → out_data=35, out_cnt=3. Flush when cnt==0 → no output.
- Reset mid-window. Feed 2 samples, assert reset for 2 cycles, then feed 1, 1, 1, 1 → out_data=4, out_cnt=4; in_ready=0 during reset and for 1 cycle after.
- Continuous stream. 8 consecutive samples 1..8, out_ready=1 → outputs 10 then 26, each out_cnt=4, no in_ready bubbles.
